// File: rtl/ioctl_pkg.sv
// Shared definitions for the hps_io ioctl side channels: upload FSM states,
// target index constants and the fill byte returned for unmapped reads.
package ioctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_READY = 2'd2,
        ST_FETCH = 2'd3
    } state_e;

    localparam logic [7:0] OOR_FILL      = 8'hFF;

    localparam logic [7:0] IDX_ROM       = 8'd0;
    localparam logic [7:0] IDX_ROM_ALT   = 8'd1;
    localparam logic [7:0] IDX_CHEATS    = 8'd2;
    localparam logic [7:0] HISCORE_INDEX = 8'd4;

    // True when a 27-bit HPS byte address lies beyond a 2**aw byte image.
    function automatic logic is_oor(input logic [26:0] addr, input int aw);
        return (addr >> aw) != 27'd0;
    endfunction

endpackage

// File: rtl/hiscore_upload_lat_shift.sv
// Valid shift register matching the RAM read latency; its last stage marks
// the cycle in which ram_q holds the requested byte.
module lat_shift #(
    parameter int DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic vld_i,
    output logic strobe_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;
    logic [DEPTH:0]   sr_ext;

    always_comb begin
        sr_ext = {sr_q, vld_i};
        sr_d   = flush_i ? '0 : sr_ext[DEPTH-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign strobe_o = sr_q[DEPTH-1];

endmodule

// File: rtl/hiscore_upload.sv
// Upload-side reader for the hps_io ioctl channel: pauses the core, then serves
// ioctl_rd requests from a core RAM with ioctl_wait throttling.
module hiscore_upload
    import ioctl_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter int         RAM_LAT      = 1,
    parameter logic [7:0] UPLOAD_INDEX = HISCORE_INDEX
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              oor_q, oor_d;
    logic              ram_rd_q, ram_rd_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_oor_q, pend_oor_d;
    logic [7:0]        din_q, din_d;
    logic              err_q, err_d;
    logic              ack_lost_q, ack_lost_d;

    logic active;
    logic rd_oor;
    logic fetch_go;
    logic queue_rd;
    logic cap_strobe;
    logic cap;
    logic accept_rd;

    assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign rd_oor = is_oor(ioctl_addr, ADDR_W);
    assign cap    = cap_strobe && (state_q == ST_FETCH);

    // Flushed on abort so a discarded fetch can never land in ioctl_din.
    lat_shift #(
        .DEPTH(RAM_LAT)
    ) u_lat (
        .clk_i   (clk_sys),
        .rst_ni  (reset_n),
        .flush_i (!active),
        .vld_i   (start_q),
        .strobe_o(cap_strobe)
    );

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        oor_d       = oor_q;
        ram_rd_d    = 1'b0;
        start_d     = 1'b0;
        busy_d      = busy_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_oor_d  = pend_oor_q;
        din_d       = din_q;
        err_d       = err_q;
        ack_lost_d  = ack_lost_q;
        fetch_go    = 1'b0;
        queue_rd    = 1'b0;

        if (!active) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            pend_d     = 1'b0;
            ack_lost_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_PAUSE;
                    if (ioctl_rd) err_d = 1'b1;
                end
                ST_PAUSE: begin
                    if (ioctl_rd && !pend_q) queue_rd = 1'b1;
                    if (pause_ack) state_d = ST_READY;
                end
                ST_READY: begin
                    if (!pause_ack) begin
                        state_d = ST_PAUSE;
                        if (ioctl_rd && !pend_q) queue_rd = 1'b1;
                    end else if (pend_q) begin
                        fetch_go   = 1'b1;
                        ram_addr_d = pend_addr_q;
                        oor_d      = pend_oor_q;
                    end else if (ioctl_rd) begin
                        fetch_go   = 1'b1;
                        ram_addr_d = ioctl_addr[ADDR_W-1:0];
                        oor_d      = rd_oor;
                    end
                end
                ST_FETCH: begin
                    if (ioctl_rd) err_d = 1'b1;
                    if (!pause_ack) ack_lost_d = 1'b1;
                    if (cap) begin
                        din_d   = oor_q ? OOR_FILL : ram_q;
                        busy_d  = 1'b0;
                        state_d = (ack_lost_q || !pause_ack) ? ST_PAUSE : ST_READY;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (queue_rd) begin
            pend_d      = 1'b1;
            pend_addr_d = ioctl_addr[ADDR_W-1:0];
            pend_oor_d  = rd_oor;
            busy_d      = 1'b1;
        end

        // Out-of-range fetches walk the same latency path without touching the RAM.
        if (fetch_go) begin
            state_d    = ST_FETCH;
            start_d    = 1'b1;
            ram_rd_d   = !oor_d;
            busy_d     = 1'b1;
            pend_d     = 1'b0;
            ack_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            oor_q       <= 1'b0;
            ram_rd_q    <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_oor_q  <= 1'b0;
            din_q       <= 8'h00;
            err_q       <= 1'b0;
            ack_lost_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            oor_q       <= oor_d;
            ram_rd_q    <= ram_rd_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_oor_q  <= pend_oor_d;
            din_q       <= din_d;
            err_q       <= err_d;
            ack_lost_q  <= ack_lost_d;
        end
    end

    // The strobe itself raises wait so hps_io sees it in the request cycle.
    assign accept_rd  = ioctl_rd && active &&
                        ((state_q == ST_PAUSE) || (state_q == ST_READY));
    assign ioctl_wait = accept_rd || busy_q;
    assign pause_req  = (state_q != ST_IDLE);
    assign ioctl_din  = din_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hiscore_upload.sv
// Scoreboard bench for hiscore_upload: reads push expected bytes, a monitor
// pops one on every falling edge of ioctl_wait and compares ioctl_din.
module tb_hiscore_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [26:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_q = 8'h00;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    logic [7:0] mem [0:1023];
    bit mon_en = 1'b1;
    bit prev_w = 1'b0;
    int w, r;

    hiscore_upload #(
        .ADDR_W(10),
        .RAM_LAT(1),
        .UPLOAD_INDEX(8'd4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_q       (ram_q),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    // One-cycle-latency model RAM.
    always @(posedge clk_sys) begin
        if (ram_rd) ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_sys) begin
        #1;
        if (mon_en && prev_w && !ioctl_wait) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                check("din", int'(ioctl_din), int'(sb.pop_front()));
            end
        end
        prev_w = ioctl_wait;
    end

    // Called at negedge+2; returns at negedge+2 of the first cycle with wait low.
    task automatic issue_rd(input logic [26:0] a, input logic [7:0] exp, input bit extra,
                            output int wcnt, output int rd_cyc);
        bit done;
        sb.push_back(exp);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        wcnt   = 0;
        rd_cyc = -1;
        done   = 1'b0;
        #2;
        if (ioctl_wait) wcnt++;
        if (ram_rd) rd_cyc = 0;
        for (int c = 1; c < 60 && !done; c++) begin
            @(negedge clk_sys);
            ioctl_rd = extra && (c == 1);
            if (extra && c == 1) ioctl_addr = 27'h20;
            #2;
            if (ram_rd && rd_cyc < 0) rd_cyc = c;
            if (!ioctl_wait) done = 1'b1;
            else wcnt++;
        end
        check("wait_timeout", int'(done), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 27'd0;
        pause_ack    = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[0] = 8'h5A;

        repeat (2) @(negedge clk_sys);
        #2;
        check("rst_din", int'(ioctl_din), 0);
        check("rst_wait", int'(ioctl_wait), 0);
        check("rst_preq", int'(pause_req), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_rd", int'(ram_rd), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk_sys) reset_n = 1'b1;

        // Upload start, ack arrives 5 cycles after the upload begins.
        @(negedge clk_sys);
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        #2 check("preq_cycle0", int'(pause_req), 0);
        @(negedge clk_sys);
        #2 check("preq_cycle1", int'(pause_req), 1);
        check("ram_rd_pause", int'(ram_rd), 0);
        @(negedge clk_sys);
        fork
            issue_rd(27'h0, 8'h5A, 1'b0, w, r);
            begin
                repeat (3) @(negedge clk_sys);
                pause_ack = 1'b1;
            end
        join
        check("pause_rd_cycle", r, 5);
        check("pause_wait_cycles", w, 7);
        check("pause_err", int'(err), 0);
        mem[0] = 8'hA5;

        // Full image sweep, back-to-back.
        for (int a = 0; a < 1024; a++) begin
            issue_rd(27'(a), 8'(a) ^ 8'hA5, 1'b0, w, r);
            check("sweep_wait_cycles", w, 3);
            check("sweep_rd_cycle", r, 1);
        end
        check("sweep_err", int'(err), 0);

        // Out-of-range address.
        issue_rd(27'h400, 8'hFF, 1'b0, w, r);
        check("oor_no_ram_rd", r, -1);
        check("oor_wait_cycles", w, 3);
        check("oor_din", int'(ioctl_din), 8'hFF);

        // Second strobe during FETCH.
        issue_rd(27'h10, 8'hB5, 1'b1, w, r);
        check("dbl_wait_cycles", w, 3);
        check("dbl_rd_cycle", r, 1);
        check("dbl_err", int'(err), 1);
        check("dbl_din", int'(ioctl_din), 8'hB5);

        // Upload dropped mid-fetch.
        mon_en     = 1'b0;
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'h30;
        @(negedge clk_sys);
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        #2;
        check("abort_wait", int'(ioctl_wait), 0);
        check("abort_preq", int'(pause_req), 0);
        check("abort_din", int'(ioctl_din), 8'hB5);
        check("abort_ram_rd", int'(ram_rd), 0);
        repeat (3) @(negedge clk_sys);
        #2;
        check("abort_din_hold", int'(ioctl_din), 8'hB5);
        check("abort_err_sticky", int'(err), 1);
        mon_en = 1'b1;

        // Reset asserted mid-fetch, then a foreign index.
        @(negedge clk_sys) ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        #2 check("reup_preq", int'(pause_req), 1);
        mon_en     = 1'b0;
        ioctl_rd   = 1'b1;
        ioctl_addr = 27'h1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        #2 check("midfetch_ram_rd", int'(ram_rd), 1);
        reset_n = 1'b0;
        #1;
        check("arst_din", int'(ioctl_din), 0);
        check("arst_wait", int'(ioctl_wait), 0);
        check("arst_preq", int'(pause_req), 0);
        check("arst_ram_addr", int'(ram_addr), 0);
        check("arst_ram_rd", int'(ram_rd), 0);
        check("arst_err", int'(err), 0);
        ioctl_index = 8'd3;
        pause_ack   = 1'b0;
        @(negedge clk_sys) reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk_sys);
            #2 check("idx3_no_preq", int'(pause_req), 0);
        end

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hiscore_upload.md
# hiscore_upload

Upload-side reader for the HPS ioctl channel: answers `ioctl_rd` requests from `hps_io` during an upload by fetching bytes from a core-side RAM (NVRAM / high-score table) and presenting them on `ioctl_din`, throttling the HPS with `ioctl_wait`. It sits between `hps_io` and the core's RAM port. It pauses the core through a request/acknowledge pair for the whole upload so the RAM port is free, complementing the `ioctl_wr` download path that fills ROMs.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width; upload image size is 2**ADDR_W bytes.
- `RAM_LAT`, 1: RAM read latency in cycles (1..3) from `ram_rd` to valid `ram_q`.
- `UPLOAD_INDEX`, 8'd4: `ioctl_index` value this block serves.

Ports:
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: level, high for the duration of an HPS upload.
- `ioctl_index` in 8: upload target index.
- `ioctl_rd` in 1: one-cycle read strobe from `hps_io`.
- `ioctl_addr` in 27: byte address of the requested read, valid with `ioctl_rd`.
- `ioctl_din` out 8: read data to `hps_io`.
- `ioctl_wait` out 1: high while the requested data is not yet valid.
- `pause_req` out 1: request for the core to release the RAM port.
- `pause_ack` in 1: core has stopped and released the RAM port.
- `ram_addr` out ADDR_W: RAM read address.
- `ram_rd` out 1: one-cycle RAM read strobe.
- `ram_q` in 8: RAM read data.
- `err` out 1: sticky protocol error flag.

## Operation
- Active when `ioctl_upload && ioctl_index == UPLOAD_INDEX`; otherwise the block stays in IDLE.
- States:
  - IDLE: all strobes low. On active, go to PAUSE.
  - PAUSE: `pause_req`=1. On `pause_ack`, go to READY.
  - READY: waits for `ioctl_rd`. On `ioctl_rd`, latch `ioctl_addr[ADDR_W-1:0]` into `ram_addr` and go to FETCH.
  - FETCH: `ram_rd` pulses on the first FETCH cycle only. A down-counter of RAM_LAT runs. When it expires, capture `ram_q` into `ioctl_din` and return to READY.
- `pause_req` stays high from PAUSE entry until IDLE is re-entered.
- Out-of-range address (`ioctl_addr >= 2**ADDR_W`): no `ram_rd`; `ioctl_din` = 8'hFF with the same latency.
- `ioctl_rd` in IDLE, PAUSE or FETCH is a protocol error:
  - In PAUSE, the request is queued (one deep) and served on entry to READY; it is not an error.
  - In FETCH, the request is ignored and `err` is set.
  - In IDLE, the request is ignored and `err` is set.
- `err` clears only on `reset_n`.
- Abort: if the active condition drops in any state, the block goes to IDLE on the next edge. Any fetch in flight is discarded, `ioctl_wait` drops and `pause_req` drops.
- `pause_ack` falling while in READY or FETCH: the block returns to PAUSE after completing any in-flight fetch.

## Timing
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `ram_addr`=0, `ram_rd`=0, `err`=0, state IDLE.
- `ioctl_wait` = `ioctl_rd` (combinational, accepted-in-READY/PAUSE term) OR a registered busy flag. The wait is therefore high in the same cycle as the strobe.
- Read with `ioctl_rd` sampled at cycle 0:
  - `ram_rd`=1 in cycle 1.
  - `ram_q` is sampled in cycle 1+RAM_LAT.
  - `ioctl_din` is valid and `ioctl_wait`=0 from cycle 2+RAM_LAT.
  - With RAM_LAT=1, wait is high in cycles 0–2 and data is valid at cycle 3.
- Back-to-back: the next `ioctl_rd` is accepted in the first cycle `ioctl_wait` is low.
- `ioctl_din` holds its value until the next capture.
- `pause_req` rises one cycle after the active condition is first seen. Reads are accepted only after `pause_ack` has been sampled high.

## Structure
- Shared package `ioctl_pkg`: state enum (IDLE, PAUSE, READY, FETCH) and the OOR fill constant 8'hFF.
- `UPLOAD_INDEX` default lives in the same package alongside the download index constants.
- One natural sub-module: `lat_shift`, a RAM_LAT-deep valid shift register generating the capture strobe.
- Everything else is flat.

## Test plan
- Upload start with `pause_ack` delayed 5 cycles: `pause_req` high at cycle 1, `ram_rd` stays low until ack, and a read of addr 0 issued during PAUSE is served after ack with the RAM byte 8'h5A.
- RAM_LAT=1, reads of addr 0x000..0x3FF back-to-back against a model RAM holding addr^0xA5: every byte matches, wait high exactly 3 cycles per read, `err`=0.
- `ioctl_addr`=0x400 with ADDR_W=10: no `ram_rd`, and `ioctl_din`=8'hFF at cycle 3.
- Second `ioctl_rd` during FETCH: it is ignored, `err`=1, and the first read still returns correct data.
- `ioctl_upload` dropped in the middle of FETCH: next cycle state is IDLE, `ioctl_wait`=0, `pause_req`=0, and `ioctl_din` is unchanged.
- `reset_n` asserted mid-fetch: all outputs immediately show their reset values; with `ioctl_index`=8'd3, no `pause_req` is issued.
